reg_file_ctx: RTL and testbench

- Parametrised successor register file: two general read ports, a dedicated accumulator read port, and a general write port plus an accumulator write port that can both commit in one cycle.
- Adds optional same-cycle write-to-read bypass.
- Adds a shadow bank with a sequential save/restore engine, one register per cycle, used for context switch/interrupt entry.
- Sits in the datapath between decode and ALU; the controller stalls on Busy.

---
 rtl/reg_file_ctx_pkg.sv | 10 +
 rtl/ctx_copy_fsm.sv | 70 +++++++
 rtl/reg_file_ctx.sv | 81 ++++++++
 tb/tb_reg_file_ctx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_ctx_pkg.sv
// Shared types for the context-switching register file.
package reg_file_ctx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2
   } ctx_state_t;

endpackage

// File: rtl/ctx_copy_fsm.sv
// Save/restore sequencer: walks idx over every register, one copy per cycle,
// and pulses Done on the cycle after the last copy.
module ctx_copy_fsm
   import reg_file_ctx_pkg::*;
#(
   parameter int A = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Save,
   input  logic         Restore,
   output logic         Busy,
   output logic         Done,
   output logic         copy_en,
   output logic         copy_save,
   output logic [A-1:0] idx
);

   localparam logic [A-1:0] LAST = '1;

   ctx_state_t   state, next_state;
   logic [A-1:0] next_idx;
   logic         next_done;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         idx   <= '0;
         Done  <= 1'b0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         Done  <= next_done;
      end
   end

   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      next_done  = 1'b0;
      case (state)
         IDLE: begin
            if (Save) begin
               next_state = SAVE;
               next_idx   = '0;
            end else if (Restore) begin
               next_state = RESTORE;
               next_idx   = '0;
            end
         end
         SAVE, RESTORE: begin
            next_idx = idx + 1'b1;
            if (idx == LAST) begin
               next_state = IDLE;
               next_done  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      Busy      = (state != IDLE);
      copy_en   = (state != IDLE);
      copy_save = (state == SAVE);
   end

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with accumulator port, optional write-to-read bypass and a
// shadow bank for context save/restore.
module reg_file_ctx
   import reg_file_ctx_pkg::*;
#(
   parameter int          W       = 8,
   parameter int          A       = 4,
   parameter int unsigned ACC_IDX = 0,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         WriteEn,
   input  logic         WriteAcc,
   input  logic [A-1:0] WrReg,
   input  logic [W-1:0] DataIn,
   input  logic [W-1:0] AccIn,
   input  logic [A-1:0] RdRegA,
   input  logic [A-1:0] RdRegB,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   output logic [W-1:0] DataOutAcc,
   input  logic         Save,
   input  logic         Restore,
   output logic         Busy,
   output logic         Done
);

   localparam int            DEPTH    = 2 ** A;
   localparam logic [A-1:0]  ACC_ADDR = A'(ACC_IDX);

   logic [W-1:0] regs   [DEPTH];
   logic [W-1:0] shadow [DEPTH];

   logic         copy_en, copy_save;
   logic [A-1:0] idx;
   logic         wr_gen, wr_acc;

   ctx_copy_fsm #(.A(A)) u_fsm (
      .Clk       (Clk),
      .Reset     (Reset),
      .Save      (Save),
      .Restore   (Restore),
      .Busy      (Busy),
      .Done      (Done),
      .copy_en   (copy_en),
      .copy_save (copy_save),
      .idx       (idx)
   );

   // Accumulator strobe loses to a general write aimed at the same register.
   assign wr_gen = WriteEn  && !Busy && !Reset;
   assign wr_acc = WriteAcc && !Busy && !Reset && !(WriteEn && WrReg == ACC_ADDR);

   // NOTE: both banks are reset explicitly because the architecture guarantees zeroed registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i]   <= '0;
            shadow[i] <= '0;
         end
      end else if (copy_en) begin
         if (copy_save) shadow[idx] <= regs[idx];
         else           regs[idx]   <= shadow[idx];
      end else begin
         if (wr_acc) regs[ACC_ADDR] <= AccIn;
         if (wr_gen) regs[WrReg]    <= DataIn;
      end
   end

   function automatic logic [W-1:0] read_port(input logic [A-1:0] addr);
      if (BYPASS && wr_gen && WrReg == addr)    return DataIn;
      if (BYPASS && wr_acc && ACC_ADDR == addr) return AccIn;
      return regs[addr];
   endfunction

   assign DataOutA   = read_port(RdRegA);
   assign DataOutB   = read_port(RdRegB);
   assign DataOutAcc = read_port(ACC_ADDR);

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx; a BYPASS=0 twin shares every input.
module tb_reg_file_ctx;

   localparam int W = 8;
   localparam int A = 4;
   localparam int DEPTH = 16;

   logic         Clk = 1'b0;
   logic         Reset, WriteEn, WriteAcc, Save, Restore;
   logic [A-1:0] WrReg, RdRegA, RdRegB;
   logic [W-1:0] DataIn, AccIn;
   logic [W-1:0] out_a, out_b, out_acc, nb_a, nb_b, nb_acc;
   logic         busy, done, nb_busy, nb_done;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   reg_file_ctx #(.W(W), .A(A), .ACC_IDX(0), .BYPASS(1'b1)) u_dut (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAcc(WriteAcc),
      .WrReg(WrReg), .DataIn(DataIn), .AccIn(AccIn),
      .RdRegA(RdRegA), .RdRegB(RdRegB),
      .DataOutA(out_a), .DataOutB(out_b), .DataOutAcc(out_acc),
      .Save(Save), .Restore(Restore), .Busy(busy), .Done(done)
   );

   reg_file_ctx #(.W(W), .A(A), .ACC_IDX(0), .BYPASS(1'b0)) u_nobyp (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAcc(WriteAcc),
      .WrReg(WrReg), .DataIn(DataIn), .AccIn(AccIn),
      .RdRegA(RdRegA), .RdRegB(RdRegB),
      .DataOutA(nb_a), .DataOutB(nb_b), .DataOutAcc(nb_acc),
      .Save(Save), .Restore(Restore), .Busy(nb_busy), .Done(nb_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Commit on the next rising edge, then settle 1ns before sampling.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic write(input logic [A-1:0] r, input logic [W-1:0] d);
      WriteEn = 1'b1; WrReg = r; DataIn = d;
      step();
      WriteEn = 1'b0;
   endtask

   task automatic expect_bank(input string tag, input logic [W-1:0] base, input bit ramp);
      for (int k = 0; k < DEPTH; k++) begin
         RdRegA = A'(k);
         RdRegB = A'(DEPTH - 1 - k);
         #1;
         check({tag, "_a"}, out_a, ramp ? base + W'(k) : base);
         check({tag, "_b"}, out_b, ramp ? base + W'(DEPTH - 1 - k) : base);
      end
   endtask

   task automatic run_copy(input string tag, input bit do_save, input bit do_restore);
      Save = do_save; Restore = do_restore;
      step();
      Save = 1'b0; Restore = 1'b0;
      for (int c = 1; c <= DEPTH; c++) begin
         check({tag, "_busy"}, busy, 1'b1);
         check({tag, "_done_early"}, done, 1'b0);
         step();
      end
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b1);
      step();
      check({tag, "_done_clr"}, done, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; WriteEn = 1'b0; WriteAcc = 1'b0; Save = 1'b0; Restore = 1'b0;
      WrReg = '0; RdRegA = '0; RdRegB = '0; DataIn = '0; AccIn = '0;
      step();
      step();
      Reset = 1'b0;

      // Reset state
      expect_bank("rst", 8'h00, 1'b0);
      check("rst_acc", out_acc, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      // Dual write to distinct registers
      WriteEn = 1'b1; WriteAcc = 1'b1; WrReg = 4'd3; DataIn = 8'h5A; AccIn = 8'h11;
      step();
      WriteEn = 1'b0; WriteAcc = 1'b0;
      RdRegA = 4'd3; RdRegB = 4'd0; #1;
      check("dual_r3", out_a, 8'h5A);
      check("dual_r0", out_b, 8'h11);
      check("dual_acc", out_acc, 8'h11);

      // Both strobes to the accumulator: general write wins
      WriteEn = 1'b1; WriteAcc = 1'b1; WrReg = 4'd0; DataIn = 8'h22; AccIn = 8'h33; #1;
      check("coll_byp_acc", out_acc, 8'h22);
      check("coll_nobyp_acc", nb_acc, 8'h11);
      step();
      WriteEn = 1'b0; WriteAcc = 1'b0; #1;
      check("coll_acc", out_acc, 8'h22);
      check("coll_nb_acc", nb_acc, 8'h22);

      // Bypass versus stored-only reads
      WriteEn = 1'b1; WrReg = 4'd7; DataIn = 8'hC3; RdRegA = 4'd7; #1;
      check("byp_a", out_a, 8'hC3);
      check("nobyp_a_old", nb_a, 8'h00);
      step();
      WriteEn = 1'b0; #1;
      check("nobyp_a_new", nb_a, 8'hC3);

      // Save/restore round trip, with a dropped write mid-save
      for (int k = 0; k < DEPTH; k++) write(A'(k), 8'h10 + W'(k));
      expect_bank("load", 8'h10, 1'b1);
      Save = 1'b1;
      step();
      Save = 1'b0;
      for (int c = 1; c <= DEPTH; c++) begin
         check("save_busy", busy, 1'b1);
         check("save_done_early", done, 1'b0);
         if (c == 5) begin
            WriteEn = 1'b1; WrReg = 4'd5; DataIn = 8'hAA; RdRegA = 4'd5; #1;
            check("busy_no_byp", out_a, 8'h15);
         end
         step();
         WriteEn = 1'b0;
      end
      check("save_busy_end", busy, 1'b0);
      check("save_done", done, 1'b1);
      RdRegA = 4'd5; #1;
      check("busy_wr_dropped", out_a, 8'h15);
      step();
      check("save_done_clr", done, 1'b0);

      for (int k = 0; k < DEPTH; k++) write(A'(k), 8'hFF);
      expect_bank("ovr", 8'hFF, 1'b0);
      run_copy("rest", 1'b0, 1'b1);
      expect_bank("rest", 8'h10, 1'b1);

      // Save and Restore together: save must be taken, leaving R3 untouched
      write(4'd3, 8'h77);
      run_copy("both", 1'b1, 1'b1);
      RdRegA = 4'd3; #1;
      check("both_r3", out_a, 8'h77);

      // Reset in the 8th save cycle aborts with no Done
      Save = 1'b1;
      step();
      Save = 1'b0;
      for (int c = 1; c < 8; c++) step();
      check("abort_busy_pre", busy, 1'b1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      expect_bank("abort", 8'h00, 1'b0);
      step();
      check("abort_no_done", done, 1'b0);
      run_copy("shadow_clr", 1'b0, 1'b1);
      expect_bank("shadow_clr", 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
